// File: rtl/control_unit_v2.sv
// control_unit_v2 -- multi-cycle control FSM for the microprocessor.
//
// Fetches an instruction over a req/ack memory handshake (any number of wait
// states), latches it into an internal IR and sequences the datapath:
// PC, MAR, register file, ALU select and data-memory strobes.
// The outputs are decoded from the state and the IR. The exceptions are
// pc_inc and the STR_DIR retire pulse, which also qualify on mem_ack.
//
// Parameters: ADDR_W (register/memory address fields), DATA_W (datapath,
//   immediate zero-extended to it), OPC_W (opcode width, >= 8).
//   Instruction word is OPC_W+3*ADDR_W: {F3, F2, F1, OPC}.
// Ports:
//   clk, rst (async, active-low)
//   instr, mem_ack                         : memory read bus / done
//   pc_inc, mar_load, mar_sel, mar_addr    : PC / MAR control
//   mem_req, mem_we                        : data-memory strobes
//   reg_re, rd_addr1, rd_addr2             : register read
//   reg_we, wr_addr, wr_sel, imm_data      : register write
//   alu_sel, flags_load                    : ALU control
//   instr_done, halted, illegal            : status
// Build option: define CU_ILLEGAL_TRAP_EN to trap on illegal opcodes. When it
//   is undefined, illegal opcodes retire as NOPs.
module control_unit_v2 #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int OPC_W  = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [OPC_W+3*ADDR_W-1:0] instr,
  input  logic                      mem_ack,
  output logic                      pc_inc,
  output logic                      mar_load,
  output logic                      mar_sel,
  output logic [ADDR_W-1:0]         mar_addr,
  output logic                      mem_req,
  output logic                      mem_we,
  output logic                      reg_re,
  output logic [ADDR_W-1:0]         rd_addr1,
  output logic [ADDR_W-1:0]         rd_addr2,
  output logic                      reg_we,
  output logic [ADDR_W-1:0]         wr_addr,
  output logic [1:0]                wr_sel,
  output logic [DATA_W-1:0]         imm_data,
  output logic [OPC_W-1:0]          alu_sel,
  output logic                      flags_load,
  output logic                      instr_done,
  output logic                      halted,
  output logic                      illegal
);
  localparam int IW = OPC_W + 3*ADDR_W;

  localparam logic [3:0] S_FETCH_ADDR = 4'd0, S_FETCH_MEM = 4'd1, S_DECODE = 4'd2,
                         S_READ       = 4'd3, S_ALU       = 4'd4, S_MEM_ADDR = 4'd5,
                         S_MEM_ACC    = 4'd6, S_WB        = 4'd7, S_HALT     = 4'd8,
                         S_TRAP       = 4'd9;

  localparam logic [OPC_W-1:0] OP_STR_IMM = OPC_W'(8'h01), OP_LOA_IMM = OPC_W'(8'h18),
                               OP_STR_DIR = OPC_W'(8'h02), OP_LOA_DIR = OPC_W'(8'h19),
                               OP_MOV     = OPC_W'(8'h1A), OP_CMP     = OPC_W'(8'h1B),
                               OP_HALT    = '1;

  logic [3:0]        state, state_nx;
  logic [IW-1:0]     ir;
  // Low from reset until the first rising edge; it holds every output at 0
  // while the state already sits at FETCH_ADDR.
  logic              run;
  logic [OPC_W-1:0]  opc;
  logic [ADDR_W-1:0] f1, f2, f3;
  logic is_imm, is_strd, is_lod, is_mov, is_alu, is_cmp, is_halt;

  assign opc = ir[OPC_W-1:0];
  assign f1  = ir[OPC_W +: ADDR_W];
  assign f2  = ir[OPC_W+ADDR_W +: ADDR_W];
  assign f3  = ir[OPC_W+2*ADDR_W +: ADDR_W];

  assign is_imm  = (opc == OP_STR_IMM) || (opc == OP_LOA_IMM);
  assign is_strd = (opc == OP_STR_DIR);
  assign is_lod  = (opc == OP_LOA_DIR);
  assign is_mov  = (opc == OP_MOV);
  assign is_cmp  = (opc == OP_CMP);
  assign is_halt = (opc == OP_HALT);
  assign is_alu  = opc inside {[OPC_W'(8'h03):OPC_W'(8'h0A)],
                               [OPC_W'(8'h0D):OPC_W'(8'h12)],
                               [OPC_W'(8'h14):OPC_W'(8'h17)]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_FETCH_ADDR;
      run   <= 1'b0;
      ir    <= '0;
    end else begin
      run   <= 1'b1;
      state <= run ? state_nx : S_FETCH_ADDR;
      if (run && state == S_FETCH_MEM && mem_ack) ir <= instr;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_FETCH_ADDR: state_nx = S_FETCH_MEM;
      S_FETCH_MEM:  if (mem_ack) state_nx = S_DECODE;
      S_DECODE: begin
        if (is_imm)                                 state_nx = S_WB;
        else if (is_mov || is_alu || is_cmp || is_strd) state_nx = S_READ;
        else if (is_lod)                            state_nx = S_MEM_ADDR;
        else if (is_halt)                           state_nx = S_HALT;
        else begin
`ifdef CU_ILLEGAL_TRAP_EN
          state_nx = S_TRAP;
`else
          state_nx = S_FETCH_ADDR;
`endif
        end
      end
      S_READ:     state_nx = (is_alu || is_cmp) ? S_ALU : (is_mov ? S_WB : S_MEM_ADDR);
      S_ALU:      state_nx = is_cmp ? S_FETCH_ADDR : S_WB;
      S_MEM_ADDR: state_nx = S_MEM_ACC;
      S_MEM_ACC:  if (mem_ack) state_nx = is_strd ? S_FETCH_ADDR : S_WB;
      S_WB:       state_nx = S_FETCH_ADDR;
      S_HALT, S_TRAP: state_nx = state;
      default:    state_nx = S_FETCH_ADDR;
    endcase
  end

  always_comb begin
    pc_inc     = 1'b0;
    mar_load   = 1'b0;
    mar_sel    = 1'b0;
    mar_addr   = '0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    reg_re     = 1'b0;
    rd_addr1   = '0;
    rd_addr2   = '0;
    reg_we     = 1'b0;
    wr_addr    = '0;
    wr_sel     = 2'b00;
    imm_data   = '0;
    alu_sel    = '0;
    flags_load = 1'b0;
    instr_done = 1'b0;
    halted     = 1'b0;
    illegal    = 1'b0;
    if (run) begin
      case (state)
        S_FETCH_ADDR: mar_load = 1'b1;
        S_FETCH_MEM: begin
          mem_req = 1'b1;
          pc_inc  = mem_ack;
        end
        S_DECODE: begin
`ifndef CU_ILLEGAL_TRAP_EN
          // Illegal opcode falls through as a one-cycle NOP retire.
          instr_done = !(is_imm || is_strd || is_lod || is_mov ||
                         is_alu || is_cmp || is_halt);
`endif
        end
        S_READ: begin
          reg_re = 1'b1;
          if (is_alu || is_cmp) begin
            rd_addr1 = f1;
            rd_addr2 = f2;
          end else begin
            rd_addr1 = f2;
          end
        end
        S_ALU: begin
          alu_sel    = opc;
          flags_load = 1'b1;
          instr_done = is_cmp;
        end
        S_MEM_ADDR: begin
          mar_sel  = 1'b1;
          mar_load = 1'b1;
          mar_addr = is_strd ? f1 : f2;
        end
        S_MEM_ACC: begin
          mem_req    = 1'b1;
          mem_we     = is_strd;
          instr_done = is_strd && mem_ack;
        end
        S_WB: begin
          reg_we     = 1'b1;
          instr_done = 1'b1;
          wr_addr    = is_alu ? f3 : f1;
          if (is_imm) begin
            wr_sel   = 2'b00;
            imm_data = DATA_W'(f2);
          end else if (is_lod) begin
            wr_sel   = 2'b01;
          end else if (is_alu) begin
            wr_sel   = 2'b10;
            alu_sel  = opc;
          end else begin
            wr_sel   = 2'b11;
          end
        end
        S_HALT: halted = 1'b1;
        S_TRAP: begin
          halted = 1'b1;
`ifdef CU_ILLEGAL_TRAP_EN
          illegal = 1'b1;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule
